five_stage_hazard_controller: RTL and testbench

Tracks destination-register state of in-flight instructions in the execute, memory and writeback stages of the five-stage pipeline. Generates per-operand hazard flags and the load-use `true_data_hazard` signal consumed by the bypass unit, and sequences decode stalls and execute bubbles. Sits beside the decode stage and feeds the bypass unit and the fetch/decode pipeline registers.

---
 rtl/five_stage_hazard_controller.sv | 119 +++++++++++
 tb/tb_five_stage_hazard_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/five_stage_hazard_controller.sv
// Hazard tracker for the EX/MEM/WB stages of the five-stage pipeline.
// Latency: hazard and stall outputs are combinational in the same cycle; stage state and the counter are registered.
// Backpressure: memory_stall freezes all stage state, and a load-use hazard holds decode for one cycle.
module five_stage_hazard_controller #(
  parameter int CORE        = 0,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   decode_valid,
  input  logic [REG_ADDR_W-1:0]  decode_rs1,
  input  logic [REG_ADDR_W-1:0]  decode_rs2,
  input  logic                   decode_rs1_used,
  input  logic                   decode_rs2_used,
  input  logic [REG_ADDR_W-1:0]  decode_rd,
  input  logic                   decode_regwrite,
  input  logic                   decode_is_load,
  input  logic                   memory_stall,
  input  logic                   flush,
  output logic                   rs1_hazard_execute,
  output logic                   rs1_hazard_memory,
  output logic                   rs1_hazard_writeback,
  output logic                   rs2_hazard_execute,
  output logic                   rs2_hazard_memory,
  output logic                   rs2_hazard_writeback,
  output logic                   true_data_hazard,
  output logic                   stall_decode,
  output logic                   bubble_execute,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Destination-register record of one in-flight instruction.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  is_load;
  } stage_t;

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d, mem_d, wb_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb;
  logic tdh_raw, stall_raw, bubble_raw;

  // A stage can only forward a real register write; x0 is never a dependency.
  function automatic logic stage_match(input stage_t s, input logic [REG_ADDR_W-1:0] rs);
    return s.valid & s.regwrite & (s.rd == rs) & (rs != '0);
  endfunction

  // Per-operand matches and load-use detection against the current stage state.
  always_comb begin
    rs1_ex     = decode_valid & decode_rs1_used & stage_match(ex_q,  decode_rs1);
    rs1_mem    = decode_valid & decode_rs1_used & stage_match(mem_q, decode_rs1);
    rs1_wb     = decode_valid & decode_rs1_used & stage_match(wb_q,  decode_rs1);
    rs2_ex     = decode_valid & decode_rs2_used & stage_match(ex_q,  decode_rs2);
    rs2_mem    = decode_valid & decode_rs2_used & stage_match(mem_q, decode_rs2);
    rs2_wb     = decode_valid & decode_rs2_used & stage_match(wb_q,  decode_rs2);
    tdh_raw    = ex_q.is_load & (rs1_ex | rs2_ex);
    stall_raw  = tdh_raw | memory_stall;
    // flush already kills the decode slot, so no separate bubble is requested then.
    bubble_raw = tdh_raw & ~memory_stall & ~flush;
  end

  // Outputs are held low for as long as reset is asserted.
  always_comb begin
    rs1_hazard_execute   = reset & rs1_ex;
    rs1_hazard_memory    = reset & rs1_mem;
    rs1_hazard_writeback = reset & rs1_wb;
    rs2_hazard_execute   = reset & rs2_ex;
    rs2_hazard_memory    = reset & rs2_mem;
    rs2_hazard_writeback = reset & rs2_wb;
    true_data_hazard     = reset & tdh_raw;
    stall_decode         = reset & stall_raw;
    bubble_execute       = reset & bubble_raw;
    stall_cycles         = reset ? stall_cycles_q : '0;
  end

  // Pipeline advance: shift stages unless memory holds; EX takes a bubble on hazard, flush or empty decode.
  always_comb begin
    ex_d           = ex_q;
    mem_d          = mem_q;
    wb_d           = wb_q;
    stall_cycles_d = stall_cycles_q;
    if (!memory_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (tdh_raw || flush || !decode_valid) begin
        ex_d = '0;
      end else begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = decode_rd;
        ex_d.regwrite = decode_regwrite;
        ex_d.is_load  = decode_is_load;
      end
    end
    if (stall_raw && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset that discards all in-flight entries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_q           <= '0;
      mem_q          <= '0;
      wb_q           <= '0;
      stall_cycles_q <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      wb_q           <= wb_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_five_stage_hazard_controller.sv
// Directed bench for five_stage_hazard_controller with a queue-based scoreboard.
// Stimulus drives one vector per cycle just after the rising edge and pushes its expected outputs.
// A monitor on the falling edge pops each expectation and compares it against the DUT.
module tb_five_stage_hazard_controller;

  localparam int AW = 5;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          decode_valid = 1'b0;
  logic [AW-1:0] decode_rs1 = '0, decode_rs2 = '0, decode_rd = '0;
  logic          decode_rs1_used = 1'b0, decode_rs2_used = 1'b0;
  logic          decode_regwrite = 1'b0, decode_is_load = 1'b0;
  logic          memory_stall = 1'b0, flush = 1'b0;
  logic          rs1_hazard_execute, rs1_hazard_memory, rs1_hazard_writeback;
  logic          rs2_hazard_execute, rs2_hazard_memory, rs2_hazard_writeback;
  logic          true_data_hazard, stall_decode, bubble_execute;
  logic [CW-1:0] stall_cycles;

  five_stage_hazard_controller #(.CORE(0), .REG_ADDR_W(AW), .STALL_CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .decode_valid(decode_valid),
    .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
    .decode_rs1_used(decode_rs1_used), .decode_rs2_used(decode_rs2_used),
    .decode_rd(decode_rd), .decode_regwrite(decode_regwrite), .decode_is_load(decode_is_load),
    .memory_stall(memory_stall), .flush(flush),
    .rs1_hazard_execute(rs1_hazard_execute), .rs1_hazard_memory(rs1_hazard_memory),
    .rs1_hazard_writeback(rs1_hazard_writeback),
    .rs2_hazard_execute(rs2_hazard_execute), .rs2_hazard_memory(rs2_hazard_memory),
    .rs2_hazard_writeback(rs2_hazard_writeback),
    .true_data_hazard(true_data_hazard), .stall_decode(stall_decode),
    .bubble_execute(bubble_execute), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst, v;
    logic [AW-1:0] rs1;
    logic          u1;
    logic [AW-1:0] rs2;
    logic          u2;
    logic [AW-1:0] rd;
    logic          rw, ld, ms, fl;
  } stim_t;

  // haz bit order: {rs1_ex, rs1_mem, rs1_wb, rs2_ex, rs2_mem, rs2_wb}
  typedef struct {
    int            id;
    logic [5:0]    haz;
    logic          tdh, sd, be;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t scb[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_id = 0;

  function automatic stim_t mk(input logic rst, input logic v,
                               input logic [AW-1:0] rs1, input logic u1,
                               input logic [AW-1:0] rs2, input logic u2,
                               input logic [AW-1:0] rd, input logic rw, input logic ld,
                               input logic ms, input logic fl);
    stim_t s;
    s.rst = rst; s.v = v; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.rw = rw; s.ld = ld; s.ms = ms; s.fl = fl;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    reset           = s.rst;
    decode_valid    = s.v;
    decode_rs1      = s.rs1;
    decode_rs1_used = s.u1;
    decode_rs2      = s.rs2;
    decode_rs2_used = s.u2;
    decode_rd       = s.rd;
    decode_regwrite = s.rw;
    decode_is_load  = s.ld;
    memory_stall    = s.ms;
    flush           = s.fl;
  endtask

  // One cycle of stimulus; the expectation is queued for the monitor.
  task automatic step(input stim_t s, input logic [5:0] haz, input logic tdh,
                      input logic sd, input logic be, input logic [CW-1:0] cnt);
    exp_t e;
    @(posedge clock);
    #1;
    apply(s);
    vec_id++;
    e.id = vec_id; e.haz = haz; e.tdh = tdh; e.sd = sd; e.be = be; e.cnt = cnt;
    scb.push_back(e);
  endtask

  task automatic check1(input int id, input string nm, input logic [CW-1:0] act,
                        input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", id, nm, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; compare whenever an expectation is pending.
  always @(negedge clock) begin
    if (scb.size() > 0) begin
      exp_t e;
      logic [5:0] haz;
      e   = scb.pop_front();
      haz = {rs1_hazard_execute, rs1_hazard_memory, rs1_hazard_writeback,
             rs2_hazard_execute, rs2_hazard_memory, rs2_hazard_writeback};
      check1(e.id, "hazards", CW'(haz), CW'(e.haz));
      check1(e.id, "true_data_hazard", CW'(true_data_hazard), CW'(e.tdh));
      check1(e.id, "stall_decode", CW'(stall_decode), CW'(e.sd));
      check1(e.id, "bubble_execute", CW'(bubble_execute), CW'(e.be));
      check1(e.id, "stall_cycles", stall_cycles, e.cnt);
    end
  end

  initial begin
    // Reset cycle: outputs forced low regardless of decode inputs.
    step(mk(0,1, 5'd5,1, 5'd5,1, 5'd5,1,1, 1,0), 6'b000000, 0,0,0, 16'd0);
    // add x5 into an empty pipeline.
    step(mk(1,1, 5'd1,1, 5'd2,1, 5'd5,1,0, 0,0), 6'b000000, 0,0,0, 16'd0);
    // sub x6 <- x5: rs1 matches EX, ALU result forwards, no stall.
    step(mk(1,1, 5'd5,1, 5'd3,1, 5'd6,1,0, 0,0), 6'b100000, 0,0,0, 16'd0);
    // store-like (rw=0, rd=7) reading x5 (MEM) and x6 (EX).
    step(mk(1,1, 5'd5,1, 5'd6,1, 5'd7,0,0, 0,0), 6'b010100, 0,0,0, 16'd0);
    // rs1=x6 in MEM, rs2=x5 in WB; EX holds a regwrite=0 entry.
    step(mk(1,1, 5'd6,1, 5'd5,1, 5'd0,0,0, 0,0), 6'b010001, 0,0,0, 16'd0);
    // lw x7: rs1=x7 only in a regwrite=0 entry, rs2=x6 unused.
    step(mk(1,1, 5'd7,1, 5'd6,0, 5'd7,1,1, 0,0), 6'b000000, 0,0,0, 16'd0);
    // add x8 <- x7 right behind the load: load-use stall and bubble.
    step(mk(1,1, 5'd1,1, 5'd7,1, 5'd8,1,0, 0,0), 6'b000100, 1,1,1, 16'd0);
    // same add retried: load now in MEM, no stall.
    step(mk(1,1, 5'd1,1, 5'd7,1, 5'd8,1,0, 0,0), 6'b000010, 0,0,0, 16'd1);
    // lw x9 reading x8 from EX (non-load, no stall).
    step(mk(1,1, 5'd8,1, 5'd0,0, 5'd9,1,1, 0,0), 6'b100000, 0,0,0, 16'd1);
    // add x10 <- x9,x9 with memory_stall held 3 cycles, then released.
    step(mk(1,1, 5'd9,1, 5'd9,1, 5'd10,1,0, 1,0), 6'b100100, 1,1,0, 16'd1);
    step(mk(1,1, 5'd9,1, 5'd9,1, 5'd10,1,0, 1,0), 6'b100100, 1,1,0, 16'd2);
    step(mk(1,1, 5'd9,1, 5'd9,1, 5'd10,1,0, 1,0), 6'b100100, 1,1,0, 16'd3);
    step(mk(1,1, 5'd9,1, 5'd9,1, 5'd10,1,0, 0,0), 6'b100100, 1,1,1, 16'd4);
    step(mk(1,1, 5'd9,1, 5'd9,1, 5'd10,1,0, 0,0), 6'b010010, 0,0,0, 16'd5);
    // lw x11 with no operands.
    step(mk(1,1, 5'd0,0, 5'd0,0, 5'd11,1,1, 0,0), 6'b000000, 0,0,0, 16'd5);
    // add x12 <- x11 (load-use) coinciding with flush: flush wins, no bubble request.
    step(mk(1,1, 5'd11,1, 5'd10,1, 5'd12,1,0, 0,1), 6'b100010, 1,1,0, 16'd5);
    // killed x12 never entered EX.
    step(mk(1,1, 5'd12,1, 5'd12,1, 5'd13,1,0, 0,0), 6'b000000, 0,0,0, 16'd6);
    // memory_stall with flush: flush ignored, x13 stays in EX.
    step(mk(1,1, 5'd13,1, 5'd0,0, 5'd14,1,0, 1,1), 6'b100000, 0,1,0, 16'd6);
    step(mk(1,1, 5'd13,1, 5'd0,0, 5'd0,0,0, 0,0), 6'b100000, 0,0,0, 16'd7);
    // Long forced stall to saturate the counter; only the final cycle is checked.
    @(posedge clock);
    #1;
    apply(mk(1,0, 5'd0,0, 5'd0,0, 5'd0,0,0, 1,0));
    repeat ((1 << CW) + 3) @(posedge clock);
    step(mk(1,0, 5'd0,0, 5'd0,0, 5'd0,0,0, 1,0), 6'b000000, 0,1,0, 16'hFFFF);
    step(mk(1,0, 5'd0,0, 5'd0,0, 5'd0,0,0, 1,0), 6'b000000, 0,1,0, 16'hFFFF);
    // Reset mid-stall with a decode that would match MEM: all outputs low.
    step(mk(0,1, 5'd13,1, 5'd0,0, 5'd0,0,0, 1,0), 6'b000000, 0,0,0, 16'd0);
    // After release: in-flight state gone, counter cleared.
    step(mk(1,1, 5'd13,1, 5'd14,1, 5'd0,0,0, 0,0), 6'b000000, 0,0,0, 16'd0);
    repeat (3) @(posedge clock);
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", scb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
